// File: rtl/count_checker.sv
// Continuity checker for a free-running up-counter stream: locks onto the
// sequence, flags breaks in continuity and counts legal wrap-arounds.
module count_checker #(
  parameter int WIDTH    = 4,
  parameter int WRAP_W   = 8,
  parameter int ERR_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              count_vld,
  input  logic              clear_err,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {UNSYNC, ACQUIRE, LOCKED} state_e;

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [3:0]       LOCK_TGT  = 4'(LOCK_CNT);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [3:0]        good_run_q, good_run_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              err_q, err_d;
  logic              err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]  prev_inc;
  logic              step_ok;

  assign prev_inc = prev_q + WIDTH'(1);
  assign step_ok  = (count_in == prev_inc);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    prev_d       = prev_q;
    good_run_d   = good_run_q;
    wrap_pulse_d = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;

    if (count_vld) begin
      prev_d = count_in;
      unique case (state_q)
        UNSYNC: begin
          state_d    = ACQUIRE;
          good_run_d = '0;
        end
        ACQUIRE: begin
          if (!step_ok) begin
            good_run_d = '0;
          end else if (good_run_q + 4'd1 == LOCK_TGT) begin
            state_d    = LOCKED;
            good_run_d = '0;
          end else begin
            good_run_d = good_run_q + 4'd1;
          end
        end
        LOCKED: begin
          if (!step_ok) begin
            err_d      = 1'b1;
            state_d    = ACQUIRE;
            good_run_d = '0;
          end else if (prev_q == COUNT_MAX) begin
            wrap_pulse_d = 1'b1;
            wrap_cnt_d   = wrap_cnt_q + WRAP_W'(1);
          end
        end
        default: state_d = UNSYNC;
      endcase
    end

    // A new error on the same edge as clear_err wins over the clear.
    if (err_d) begin
      err_sticky_d = 1'b1;
      if (clear_err)                err_cnt_d = ERR_W'(1);
      else if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
    end else if (clear_err) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= UNSYNC;
      prev_q       <= '0;
      good_run_q   <= '0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_run_q   <= good_run_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Downstream consumer of the 4-bit free-running up-counter output.
- Samples the count stream and checks that each valid sample is exactly the previous sample plus one, modulo 2^WIDTH.
- Locks onto the sequence and reports wrap-around events and continuity errors.
- Sits directly after the counter; its flags drive status and debug logic.

Parameters:
- WIDTH, 4, width of the checked count.
- WRAP_W, 8, width of the wrap-event counter; wraps modulo 2^WRAP_W.
- ERR_W, 8, width of the error counter; saturates at all-ones.
- LOCK_CNT, 2, number of consecutive correct increments needed to enter LOCKED; valid range 1 to 15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- count_in  in  WIDTH  count value from the upstream counter.
- count_vld  in  1  count_in is sampled only on cycles where this is high.
- clear_err  in  1  clears err_sticky and err_cnt.
- locked  out  1  high while the FSM is in LOCKED.
- wrap_pulse  out  1  one-cycle pulse on a legal wrap from max to 0 while LOCKED.
- wrap_cnt  out  WRAP_W  number of legal wraps seen while LOCKED.
- err  out  1  one-cycle pulse on a continuity break while LOCKED.
- err_sticky  out  1  set by err; held until clear_err or reset.
- err_cnt  out  ERR_W  saturating count of err pulses.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=UNSYNC; prev=0; good_run=0.
  - All outputs 0.
  - Reset has priority over every other input, including mid-lock.
- Registered outputs: every output reflects the sample taken at edge N from edge N onward, a 1-cycle latency.
- count_vld=0: state, prev, good_run and counters hold; wrap_pulse and err are 0.
- step_ok: count_in == (prev+1) mod 2^WIDTH. A repeated value or a skipped value is not ok.
- prev is loaded with count_in on every valid sample, in every state.
- FSM on a valid sample:
  - UNSYNC: go to ACQUIRE; good_run=0. No step check is made.
  - ACQUIRE:
    - step_ok: good_run+1.
    - If good_run+1 == LOCK_CNT: go to LOCKED and clear good_run.
    - Not ok: good_run=0; stay in ACQUIRE; no err.
  - LOCKED, step_ok: stay in LOCKED.
  - LOCKED, step_ok with prev=2^WIDTH-1 and count_in=0:
    - wrap_pulse=1 for one cycle.
    - wrap_cnt+1, rolling over from all-ones to 0.
  - LOCKED, not ok:
    - err=1 for one cycle; err_sticky=1.
    - err_cnt+1, saturating at 2^ERR_W-1.
    - Go to ACQUIRE with good_run=0; locked falls on the same edge.
- A wrap seen in UNSYNC or ACQUIRE does not pulse and is not counted.
- clear_err=1:
  - err_sticky=0 and err_cnt=0 at the next edge. wrap_cnt is not affected.
  - If a new error occurs on the same edge, the error wins: err_sticky=1 and err_cnt=1.
- clear_err does not change FSM state.

Test Plan:
- Reset held low for 3 clocks, then released; count_vld=1 with counts 5,6,7,8 -> locked=1 after the edge sampling 7 (LOCK_CNT=2); err and err_sticky stay 0; wrap_cnt=0.
- Locked, feed counts 14,15,0,1 -> wrap_pulse=1 for exactly the cycle after 0 is sampled; wrap_cnt=1; locked stays 1.
- Locked at 3, feed 5 -> err=1 for one cycle; err_sticky=1; err_cnt=1; locked=0. Then 6,7 -> locked=1 again; err_sticky still 1.
- Locked at 9, hold count_vld=0 for 10 cycles, then feed 10 -> no err; locked stays 1. Separately, feed a repeated 9 while locked -> err=1.
- Six forced errors with ERR_W=2 -> err_cnt saturates at 3. Then clear_err together with a new error -> err_sticky=1, err_cnt=1. Then clear_err alone -> err_sticky=0, err_cnt=0.
- While locked with wrap_cnt=4, assert rst=0 for one edge -> all outputs 0 and state UNSYNC. Then feed 0,1,2 -> relock without err.
